// File: rtl/ecsu_pkg.sv
// Shared encodings and defaults for the ECSU weather unit and the runway arbiter.
package ecsu_pkg;

    localparam int DEF_DEPTH   = 4;
    localparam int DEF_ID_W    = 4;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ECSU_ALL_CLEAR = 2'b00,
        ECSU_CAUTION   = 2'b01,
        ECSU_HIGH_RISK = 2'b10,
        ECSU_EMERGENCY = 2'b11
    } ecsu_state_e;

    typedef enum logic [1:0] {
        RW_IDLE    = 2'b00,
        RW_LANDING = 2'b01,
        RW_TAKEOFF = 2'b10
    } rw_state_e;

    // Takeoffs need clear weather, no landing emergency and an ECSU state below emergency.
    function automatic logic takeoff_ok(input logic severe, input logic alert,
                                        input logic [1:0] st);
        return !severe && !alert && (st != ECSU_EMERGENCY);
    endfunction

endpackage

// File: rtl/rcc_id_fifo.sv
// Circular FIFO of aircraft ids with a count register and a synchronous flush.
module rcc_id_fifo
    import ecsu_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int ID_W  = DEF_ID_W
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_flush,
    input  logic [ID_W-1:0] i_din,
    output logic            o_full,
    output logic            o_empty,
    output logic [ID_W-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [ID_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_cnt;
    logic            w_push_ok;
    logic            w_pop_ok;

    // Full/empty come from the pre-edge count, so a push to a full queue is refused
    // even when a pop happens on the same edge. Flush wins over both.
    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full && !i_flush;
    assign w_pop_ok  = i_pop && !o_empty && !i_flush;

    // Storage write; contents need no reset since the count gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
    end

    // Pointer and count bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_cnt    <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/runway_clearance_ctrl.sv
// Single-runway arbiter: landing priority, weather-gated takeoffs, grant timeout.
module runway_clearance_ctrl
    import ecsu_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ID_W    = DEF_ID_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            severe_weather,
    input  logic            emergency_landing_alert,
    input  logic [1:0]      ECSU_state,
    input  logic            landing_request,
    input  logic            takeoff_request,
    input  logic [ID_W-1:0] plane_id,
    input  logic            runway_done,
    output logic            landing_granted,
    output logic            takeoff_granted,
    output logic [ID_W-1:0] granted_id,
    output logic            landing_full,
    output logic            takeoff_full,
    output logic            dropped,
    output logic            timeout_err,
    output logic [1:0]      runway_state
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    rw_state_e       r_state, w_nxt_state;
    logic [CW-1:0]   r_cnt, w_nxt_cnt;
    logic [ID_W-1:0] r_gid, w_nxt_gid;
    logic            r_lg, w_nxt_lg;
    logic            r_tg, w_nxt_tg;
    logic            r_to, w_nxt_to;
    logic            r_dropped;

    logic            w_land_pop, w_to_pop;
    logic            w_land_empty, w_to_empty;
    logic            w_land_full, w_to_full;
    logic [ID_W-1:0] w_land_head, w_to_head;
    logic            w_to_ok;
    logic            w_drop;

    assign w_to_ok = takeoff_ok(severe_weather, emergency_landing_alert, ECSU_state);

    rcc_id_fifo #(.DEPTH(DEPTH), .ID_W(ID_W)) u_land_q (
        .i_clk(CLK), .i_rst(RST), .i_push(landing_request), .i_pop(w_land_pop),
        .i_flush(1'b0), .i_din(plane_id), .o_full(w_land_full),
        .o_empty(w_land_empty), .o_head(w_land_head)
    );

    rcc_id_fifo #(.DEPTH(DEPTH), .ID_W(ID_W)) u_to_q (
        .i_clk(CLK), .i_rst(RST), .i_push(takeoff_request), .i_pop(w_to_pop),
        .i_flush(emergency_landing_alert), .i_din(plane_id), .o_full(w_to_full),
        .o_empty(w_to_empty), .o_head(w_to_head)
    );

    // A takeoff request discarded by the emergency flush is not a drop.
    assign w_drop = (landing_request && w_land_full) ||
                    (takeoff_request && w_to_full && !emergency_landing_alert);

    // Next-state: grant from IDLE (landing first), release on done or timeout.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_gid   = r_gid;
        w_nxt_lg    = 1'b0;
        w_nxt_tg    = 1'b0;
        w_nxt_to    = 1'b0;
        w_land_pop  = 1'b0;
        w_to_pop    = 1'b0;
        case (r_state)
            RW_IDLE: begin
                if (!w_land_empty) begin
                    w_nxt_state = RW_LANDING;
                    w_land_pop  = 1'b1;
                    w_nxt_gid   = w_land_head;
                    w_nxt_lg    = 1'b1;
                    w_nxt_cnt   = '0;
                end else if (!w_to_empty && w_to_ok) begin
                    w_nxt_state = RW_TAKEOFF;
                    w_to_pop    = 1'b1;
                    w_nxt_gid   = w_to_head;
                    w_nxt_tg    = 1'b1;
                    w_nxt_cnt   = '0;
                end
            end
            RW_LANDING, RW_TAKEOFF: begin
                if (runway_done) begin
                    w_nxt_state = RW_IDLE;
                    w_nxt_cnt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_nxt_state = RW_IDLE;
                    w_nxt_to    = 1'b1;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt   = r_cnt + 1'b1;
                end
            end
            default: w_nxt_state = RW_IDLE;
        endcase
    end

    // State, grant outputs and the sticky drop flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= RW_IDLE;
            r_cnt     <= '0;
            r_gid     <= '0;
            r_lg      <= 1'b0;
            r_tg      <= 1'b0;
            r_to      <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_cnt     <= w_nxt_cnt;
            r_gid     <= w_nxt_gid;
            r_lg      <= w_nxt_lg;
            r_tg      <= w_nxt_tg;
            r_to      <= w_nxt_to;
            r_dropped <= r_dropped | w_drop;
        end
    end

    assign landing_granted = r_lg;
    assign takeoff_granted = r_tg;
    assign granted_id      = r_gid;
    assign landing_full    = w_land_full;
    assign takeoff_full    = w_to_full;
    assign dropped         = r_dropped;
    assign timeout_err     = r_to;
    assign runway_state    = r_state;

endmodule
